// File: rtl/mux_4ch_scanner_pkg.sv
// Shared types and constants for the 4-channel MUX scanner: FSM state encoding,
// channel geometry and the helper that finds the next enabled channel.
package mux_4ch_scanner_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  // Returns {found, index} of the lowest enabled channel whose index is >= start.
  function automatic logic [SEL_W:0] next_enabled(input logic [NUM_CH-1:0] mask,
                                                  input logic [SEL_W:0]    start);
    logic [SEL_W:0] hit;
    hit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((i >= int'(start)) && mask[i]) begin
        hit = {1'b1, SEL_W'(i)};
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/mux_4ch_scanner_if.sv
// Scanner-to-MUX / scanner-to-consumer signal bundle.
// MUX_SCAN_MASK_EN adds the ch_mask channel-enable input.
interface mux_4ch_scanner_if #(
  parameter int CNT_W = 8
);

  logic             en;
  logic             y;
  logic             s0;
  logic             s1;
  logic [3:0]       frame;
  logic             frame_valid;
  logic             frame_ready;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
`ifdef MUX_SCAN_MASK_EN
  logic [3:0]       ch_mask;

  modport master (
    input  en, y, frame_ready, ch_mask,
    output s0, s1, frame, frame_valid, busy, frame_cnt
  );

  modport slave (
    output en, y, frame_ready, ch_mask,
    input  s0, s1, frame, frame_valid, busy, frame_cnt
  );
`else
  modport master (
    input  en, y, frame_ready,
    output s0, s1, frame, frame_valid, busy, frame_cnt
  );

  modport slave (
    output en, y, frame_ready,
    input  s0, s1, frame, frame_valid, busy, frame_cnt
  );
`endif

endinterface

// File: rtl/mux_4ch_scanner_settle_timer.sv
// Load/count/done down-counter that times how long the select lines are held
// before the MUX output is sampled.
module mux_4ch_scanner_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(SETTLE_CYCLES - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mux_4ch_scanner.sv
// Sequencer that walks a 4:1 MUX through its channels, samples Y and hands the
// assembled 4-bit frame to a consumer. MUX_SCAN_MASK_EN enables per-channel masking.
module mux_4ch_scanner
  import mux_4ch_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_4ch_scanner_if.master   bus
);

  state_e              state_q;
  state_e              state_d;
  logic [SEL_W-1:0]    ch_q;
  logic [SEL_W-1:0]    ch_d;
  logic [NUM_CH-1:0]   shadow_q;
  logic [NUM_CH-1:0]   shadow_d;
  logic [NUM_CH-1:0]   shadow_with_y;
  logic [NUM_CH-1:0]   frame_q;
  logic [NUM_CH-1:0]   frame_d;
  logic [NUM_CH-1:0]   mask_q;
  logic [NUM_CH-1:0]   mask_d;
  logic [NUM_CH-1:0]   mask_in;
  logic [CNT_W-1:0]    frame_cnt_q;
  logic [CNT_W-1:0]    frame_cnt_d;
  logic                frame_start;
  logic                sample_hit;
  logic                timer_load;
  logic                timer_dec;
  logic                timer_done;
  logic [SEL_W:0]      first_hit;
  logic [SEL_W:0]      next_hit;

`ifdef MUX_SCAN_MASK_EN
  assign mask_in = bus.ch_mask;
`else
  assign mask_in = '1;
`endif

  assign first_hit = next_enabled(mask_in, '0);
  assign next_hit  = next_enabled(mask_q, {1'b0, ch_q} + (SEL_W + 1)'(1));

  // Shadow word with the current channel's bit replaced by the live MUX output.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_shadow
      assign shadow_with_y[gi] = (ch_q == SEL_W'(gi)) ? bus.y : shadow_q[gi];
    end
  endgenerate

  mux_4ch_scanner_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .dec   (timer_dec),
    .done  (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    frame_d     = frame_q;
    mask_d      = mask_q;
    frame_cnt_d = frame_cnt_q;
    frame_start = 1'b0;
    sample_hit  = 1'b0;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ch_d = '0;
        if (bus.en) begin
          frame_start = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
          ch_d    = '0;
        end else if (!mask_q[ch_q]) begin
          // Only reachable with an all-zero mask: emit an empty frame.
          state_d = ST_OUTPUT;
          frame_d = '0;
        end else if (timer_done) begin
          state_d = ST_SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
          ch_d    = '0;
        end else begin
          sample_hit = 1'b1;
          if (next_hit[SEL_W]) begin
            state_d    = ST_SETTLE;
            ch_d       = next_hit[SEL_W-1:0];
            timer_load = 1'b1;
          end else begin
            state_d = ST_OUTPUT;
            frame_d = shadow_with_y;
          end
        end
      end
      ST_OUTPUT: begin
        if (bus.frame_ready) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          if (bus.en) begin
            frame_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
            ch_d    = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end
    endcase

    // Common frame-start path: latch the mask and jump to the first enabled channel.
    if (frame_start) begin
      state_d    = ST_SETTLE;
      ch_d       = first_hit[SEL_W] ? first_hit[SEL_W-1:0] : '0;
      mask_d     = mask_in;
      timer_load = 1'b1;
    end

    if (frame_start) begin
      shadow_d = '0;
    end else if (sample_hit) begin
      shadow_d = shadow_with_y;
    end else begin
      shadow_d = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      shadow_q    <= '0;
      frame_q     <= '0;
      mask_q      <= '1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      mask_q      <= mask_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.s0          = ch_q[0];
  assign bus.s1          = ch_q[1];
  assign bus.frame       = frame_q;
  assign bus.frame_valid = (state_q == ST_OUTPUT);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_mux_4ch_scanner.sv
// Directed bench for mux_4ch_scanner with a behavioural 4:1 MUX closing the loop.
// Mask scenarios are compiled in when MUX_SCAN_MASK_EN is defined.
module tb_mux_4ch_scanner;

  localparam int CNT_W = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_data;

  int n_checks;
  int n_pass;

  logic [3:0] sb[$];

  mux_4ch_scanner_if #(.CNT_W(CNT_W)) bus ();

  mux_4ch_scanner #(
    .SETTLE_CYCLES (1),
    .CNT_W         (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural 4:1 MUX fed by the scanner's select lines.
  assign bus.y = i_data[{bus.s1, bus.s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (!bus.frame_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check("valid_timeout", {31'd0, bus.frame_valid}, 32'd1);
  endtask

  task automatic sb_check();
    logic [3:0] exp;
    check("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check("frame", {28'd0, bus.frame}, {28'd0, exp});
      $display("[%0t] frame observed=%b expected=%b cnt=%0d", $time, bus.frame, exp, bus.frame_cnt);
    end
  endtask

  initial begin
    logic [3:0] visited;
    logic [3:0] held;
    int         exp_sel;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    i_data   = 4'b0000;
    bus.en          = 1'b0;
    bus.frame_ready = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    bus.ch_mask = 4'hF;
`endif

    // Reset values
    tick();
    tick();
    check("rst_sel",   {30'd0, bus.s1, bus.s0}, 32'd0);
    check("rst_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("rst_frame", {28'd0, bus.frame}, 32'd0);
    check("rst_cnt",   {30'd0, bus.frame_cnt}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic scan with latency and select sequence; consumer not yet ready
    i_data = 4'b1010;
    bus.en = 1'b1;
    sb.push_back(4'b1010);
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_sel = (k <= 8) ? (k - 1) / 2 : 3;
      check("scan_sel",   {30'd0, bus.s1, bus.s0}, 32'(exp_sel));
      check("scan_valid", {31'd0, bus.frame_valid}, {31'd0, (k == 9)});
    end
    check("scan_busy", {31'd0, bus.busy}, 32'd1);
    sb_check();

    // Backpressure: frame and selects frozen while input data changes
    held   = 4'b1010;
    i_data = 4'b0101;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("bp_frame", {28'd0, bus.frame}, {28'd0, held});
      check("bp_sel",   {30'd0, bus.s1, bus.s0}, 32'd3);
      check("bp_valid", {31'd0, bus.frame_valid}, 32'd1);
      check("bp_cnt",   {30'd0, bus.frame_cnt}, 32'd0);
    end
    bus.frame_ready = 1'b1;
    tick();
    check("acc_cnt",   {30'd0, bus.frame_cnt}, 32'd1);
    check("acc_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("acc_sel",   {30'd0, bus.s1, bus.s0}, 32'd0);
    check("acc_busy",  {31'd0, bus.busy}, 32'd1);

    // Back-to-back frame started by the accept edge
    sb.push_back(4'b0101);
    wait_valid(20);
    sb_check();
    bus.en = 1'b0;
    tick();
    check("f2_cnt",  {30'd0, bus.frame_cnt}, 32'd2);
    check("f2_busy", {31'd0, bus.busy}, 32'd0);

    // Abort while channel 2 is selected
    i_data = 4'b1111;
    bus.en = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("abort_pre_sel", {30'd0, bus.s1, bus.s0}, 32'd2);
    bus.en = 1'b0;
    tick();
    check("abort_busy",  {31'd0, bus.busy}, 32'd0);
    check("abort_sel",   {30'd0, bus.s1, bus.s0}, 32'd0);
    check("abort_frame", {28'd0, bus.frame}, 32'h5);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("abort_valid", {31'd0, bus.frame_valid}, 32'd0);
    end

    // Asynchronous reset in the middle of a scan
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",  {31'd0, bus.busy}, 32'd0);
    check("arst_sel",   {30'd0, bus.s1, bus.s0}, 32'd0);
    check("arst_frame", {28'd0, bus.frame}, 32'd0);
    check("arst_cnt",   {30'd0, bus.frame_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Counter wrap over five accepted frames with random MUX inputs
    for (int f = 0; f < 5; f++) begin
      i_data = 4'($urandom_range(0, 15));
      sb.push_back(i_data);
      wait_valid(30);
      sb_check();
      if (f == 4) bus.en = 1'b0;
      tick();
      check("wrap_cnt", {30'd0, bus.frame_cnt}, 32'((f + 1) % 4));
    end

`ifdef MUX_SCAN_MASK_EN
    // Mask 0101: only channels 0 and 2 visited, masked bits read as 0
    bus.ch_mask = 4'b0101;
    i_data      = 4'b1111;
    sb.push_back(4'b0101);
    bus.en  = 1'b1;
    visited = 4'b0000;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.frame_valid) break;
      visited[{bus.s1, bus.s0}] = 1'b1;
    end
    check("mask_visited", {28'd0, visited}, 32'h5);
    sb_check();
    bus.en = 1'b0;
    tick();
    check("mask_cnt", {30'd0, bus.frame_cnt}, 32'd2);

    // Empty mask: empty frame one cycle after frame start
    bus.ch_mask = 4'b0000;
    sb.push_back(4'b0000);
    bus.en = 1'b1;
    tick();
    tick();
    check("mask0_valid", {31'd0, bus.frame_valid}, 32'd1);
    sb_check();
    bus.en = 1'b0;
    tick();
    check("mask0_cnt", {30'd0, bus.frame_cnt}, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
